mainfsm_param: RTL
==================

MAINFSM_PARAM -- requirements
Module: mainfsm_param

Interface
REQ-001 Parameter MEM_HS, default 0; 1 means FETCH, MEMRD and MEMWR hold until mem_ready=1, and 0 means those states complete in one cycle with mem_ready ignored.
REQ-002 Parameter FPU_LAT, default 4, range 1..15; it sets the number of cycles spent in EXECUTEF.
REQ-003 Parameter LMUL_EN, default 1; 0 means the long input is ignored and ALUWB2 is unreachable.
REQ-004 The design SHALL use one clock; reset is synchronous and active-high. Port clk (input, 1): rising-edge clock. Port reset (input, 1): synchronous active-high reset.
REQ-005 Port Op (input, 2): instruction class field.
REQ-006 Port Funct (input, 6): function field; bit5 is the immediate select and bit0 is the load/store select.
REQ-007 Port long (input, 1): long-multiply request, sampled in EXECUTER and EXECUTEI.
REQ-008 Port mem_ready (input, 1): memory access complete.
REQ-009 Ports NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ALUOp, lmulFlag and FpuW (output, 1 each): datapath strobes.
REQ-010 Ports ResultSrc, ALUSrcA and ALUSrcB (output, 2 each): datapath mux selects.
REQ-011 Port state_o (output, 4): current state code.
REQ-012 Port illegal_op (output, 1): sticky flag, set on entering UNKNOWN.
REQ-013 Port fpu_busy (output, 1): high while in EXECUTEF.

Function
REQ-014 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10, EXECUTEF=11, FPUWB=12, ALUWB2=13.
REQ-015 FETCH SHALL go to DECODE when MEM_HS=0 or mem_ready=1; otherwise it stays in FETCH.
REQ-016 DECODE SHALL branch on Op: 00 goes to EXECUTEI if Funct[5]=1, else EXECUTER; 01 goes to MEMADR; 10 goes to BRANCH; 11 goes to EXECUTEF.
REQ-017 MEMADR SHALL go to MEMRD if Funct[0]=1, else MEMWR.
REQ-018 MEMRD SHALL go to MEMWB, and MEMWR SHALL go to FETCH; both follow the same ready rule as FETCH.
REQ-019 EXECUTER and EXECUTEI SHALL go to ALUWB2 if LMUL_EN=1 and long=1, else ALUWB.
REQ-020 EXECUTEF SHALL load a 4-bit down-counter with FPU_LAT-1 on entry and go to FPUWB when the counter equals 0; FPU_LAT=1 therefore gives one cycle.
REQ-021 MEMWB, ALUWB, ALUWB2, FPUWB, BRANCH and UNKNOWN SHALL each go to FETCH after one cycle; any unused state code SHALL go to FETCH.
REQ-022 Control outputs are a function of state only, listed as NextPC Branch MemW RegW IRWrite AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp lmulFlag FpuW:
  - FETCH: 1 0 0 0 1 0 10 01 10 0 0 0
  - DECODE: 0 0 0 0 0 0 10 01 10 0 0 0
  - EXECUTER: 0 0 0 0 0 0 00 00 00 1 0 0
  - EXECUTEI: 0 0 0 0 0 0 00 00 01 1 0 0
  - ALUWB: 0 0 0 1 0 0 00 00 00 0 0 0
  - ALUWB2: 0 0 0 1 0 0 00 00 00 0 1 0
  - MEMADR: 0 0 0 0 0 0 00 00 01 0 0 0
  - MEMRD: 0 0 0 0 0 1 00 00 00 0 0 0
  - MEMWR: 0 0 1 0 0 1 00 00 00 0 0 0
  - MEMWB: 0 0 0 1 0 0 01 00 00 0 0 0
  - BRANCH: 0 1 0 0 0 0 10 00 01 0 0 0
  - FPUWB: 0 0 0 0 0 0 00 00 00 0 0 1
  - EXECUTEF and UNKNOWN: all zero
REQ-023 When MEM_HS=1 and FETCH is waiting, NextPC and IRWrite SHALL be asserted only in the cycle where mem_ready=1, so the PC advances exactly once per fetch.
REQ-024 MemW and AdrSrc SHALL stay asserted in every MEMWR hold cycle, and AdrSrc in every MEMRD hold cycle.
REQ-025 illegal_op SHALL set on the clock edge entering UNKNOWN and clear only on reset; UNKNOWN is reachable only by forcing an out-of-range state, and a bench reaches it by that means.
REQ-026 fpu_busy SHALL equal (state==EXECUTEF).
REQ-027 Outputs SHALL contain no X in any reachable state; unused codes SHALL drive all-zero controls.

Reset
REQ-028 Reset is sampled on the rising edge of clk only; after that edge: state=FETCH, state_o=0, FPU counter=0, illegal_op=0.
REQ-029 Reset asserted mid-instruction, including in an EXECUTEF countdown or a memory wait, SHALL abandon the instruction, and the next state SHALL be FETCH.
REQ-030 Between the reset edge and the first clock, outputs SHALL show the FETCH row.

Verification
REQ-031 Scenario: Op=00, Funct=6'b100000, long=0, MEM_HS=0 -> states 0,1,7,8,0; RegW=1 only in the ALUWB cycle; 4 cycles total.
REQ-032 Scenario: Op=00, Funct=0, long=1, LMUL_EN=1 -> states 0,1,6,13,0; lmulFlag=1 and RegW=1 in the same cycle; with LMUL_EN=0 the same stimulus gives 0,1,6,8,0.
REQ-033 Scenario: Op=11, FPU_LAT=4 -> EXECUTEF for exactly 4 cycles with fpu_busy=1, then FPUWB with FpuW=1 for 1 cycle, then FETCH; with FPU_LAT=1, EXECUTEF lasts 1 cycle.
REQ-034 Scenario: MEM_HS=1, load (Op=01, Funct[0]=1), mem_ready low for 3 cycles in FETCH and 2 in MEMRD -> NextPC pulses exactly once; states FETCH x4, 1, 2, MEMRD x3, 4, 0.
REQ-035 Scenario: store with MEM_HS=1 -> MemW=1 in every MEMWR cycle until mem_ready=1, then FETCH.
REQ-036 Scenario: reset in the 2nd EXECUTEF cycle -> state_o=0 after that edge and no FpuW pulse; a forced state of 10 -> illegal_op=1 until the next reset.

Source files
------------

// File: rtl/mainfsm_param_if.sv
// Instruction-level control bus between the multicycle controller and its datapath.
// The datapath (or a bench) drives the decode fields and the memory ready; the controller drives the strobes.
interface mainfsm_param_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       long;
  logic       mem_ready;
  logic       NextPC;
  logic       Branch;
  logic       MemW;
  logic       RegW;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUOp;
  logic       lmulFlag;
  logic       FpuW;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] state_o;
  logic       illegal_op;
  logic       fpu_busy;

  modport master (
    output Op, Funct, long, mem_ready,
    input  NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ALUOp, lmulFlag, FpuW,
    input  ResultSrc, ALUSrcA, ALUSrcB, state_o, illegal_op, fpu_busy
  );

  modport slave (
    input  Op, Funct, long, mem_ready,
    output NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ALUOp, lmulFlag, FpuW,
    output ResultSrc, ALUSrcA, ALUSrcB, state_o, illegal_op, fpu_busy
  );
endinterface

// File: rtl/mainfsm_param.sv
// Multicycle main controller: fetch/decode/execute FSM with optional memory handshake,
// multi-cycle FPU execute and long-multiply writeback. Control strobes decode from the state register.
module mainfsm_param #(
  parameter bit          MEM_HS  = 1'b0,
  parameter int unsigned FPU_LAT = 4,
  parameter bit          LMUL_EN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mainfsm_param_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10,
    EXECUTEF = 4'd11,
    FPUWB    = 4'd12,
    ALUWB2   = 4'd13
  } state_e;

  localparam logic [3:0] FPU_LOAD = 4'(FPU_LAT - 1);

  logic [3:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        illegal_q;
  logic        mem_go;
  logic        long_go;
  logic [14:0] ctrl;
  logic        unused_funct;

  // Without the handshake, memory states always complete in one cycle.
  assign mem_go       = !MEM_HS || bus.mem_ready;
  assign long_go      = LMUL_EN && bus.long;
  assign unused_funct = ^bus.Funct[4:1];

  always_comb begin
    state_d = FETCH;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH:  state_d = mem_go ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: begin
            state_d = EXECUTEF;
            cnt_d   = FPU_LOAD;
          end
        endcase
      end
      MEMADR:             state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:              state_d = mem_go ? MEMWB : MEMRD;
      MEMWR:              state_d = mem_go ? FETCH : MEMWR;
      EXECUTER, EXECUTEI: state_d = long_go ? ALUWB2 : ALUWB;
      EXECUTEF: begin
        if (cnt_q == 4'd0) begin
          state_d = FPUWB;
        end else begin
          state_d = EXECUTEF;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default:            state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // UNKNOWN is only reachable by an upset of the state register, so latch on either side of it.
      illegal_q <= illegal_q || (state_d == UNKNOWN) || (state_q == UNKNOWN);
    end
  end

  // Field order: NextPC Branch MemW RegW IRWrite AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp lmulFlag FpuW
  always_comb begin
    ctrl = 15'd0;
    case (state_q)
      FETCH:    ctrl = {mem_go, 3'b000, mem_go, 1'b0, 2'b10, 2'b01, 2'b10, 3'b000};
      DECODE:   ctrl = 15'b000000_10_01_10_000;
      EXECUTER: ctrl = 15'b000000_00_00_00_100;
      EXECUTEI: ctrl = 15'b000000_00_00_01_100;
      ALUWB:    ctrl = 15'b000100_00_00_00_000;
      ALUWB2:   ctrl = 15'b000100_00_00_00_010;
      MEMADR:   ctrl = 15'b000000_00_00_01_000;
      MEMRD:    ctrl = 15'b000001_00_00_00_000;
      MEMWR:    ctrl = 15'b001001_00_00_00_000;
      MEMWB:    ctrl = 15'b000100_01_00_00_000;
      BRANCH:   ctrl = 15'b010000_10_00_01_000;
      FPUWB:    ctrl = 15'b000000_00_00_00_001;
      default:  ctrl = 15'd0;
    endcase
  end

  assign {bus.NextPC, bus.Branch, bus.MemW, bus.RegW, bus.IRWrite, bus.AdrSrc,
          bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.lmulFlag, bus.FpuW} = ctrl;

  assign bus.state_o    = state_q;
  assign bus.illegal_op = illegal_q;
  assign bus.fpu_busy   = (state_q == EXECUTEF);

endmodule
